systolic_row_skew_feeder: RTL

- Upstream feeder for the systolic PE array.
- Accepts one N-lane FP32 operand vector per handshake and buffers vectors in a small FIFO.
- Drives lane i onto PE row i delayed by i cycles, producing the diagonal wavefront the array needs.
- Injects FP32 +0.0 (0x00000000) bubbles when idle; pulses tile_done once the last element of a tile has entered the array.

---
 rtl/systolic_row_skew_feeder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/systolic_row_skew_feeder.sv
// rtl/systolic_row_skew_feeder.sv - operand FIFO plus per-row skew chains feeding a systolic PE array
module systolic_row_skew_feeder #(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N*DW-1:0]          in_data,
   input  logic                     in_last,
   input  logic                     en,
   output logic [N*DW-1:0]          row_a,
   output logic [N-1:0]             row_valid,
   output logic                     tile_done,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int DCW = $clog2(N) + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [N*DW:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [1:0]       r_state;
   logic [DCW-1:0]   r_drain_cnt;

   logic             w_push;
   logic             w_pop;
   logic             w_head_last;
   logic [N*DW-1:0]  w_head_data;

   // Ready depends only on the registered count, so a full FIFO never accepts even when popping.
   assign in_ready   = !rst && (r_count < CW'(DEPTH));
   assign w_push     = in_valid && in_ready;
   assign w_pop      = en && (r_count != '0) && ((r_state == S_IDLE) || (r_state == S_STREAM));
   assign {w_head_last, w_head_data} = r_mem[r_rd_ptr];
   assign fifo_count = r_count;
   assign tile_done  = (r_state == S_DONE);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_last, in_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_drain_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_STREAM: begin
               if (w_pop && w_head_last) begin
                  r_state     <= (N == 1) ? S_DONE : S_DRAIN;
                  r_drain_cnt <= DCW'(N - 1);
               end else if (w_pop) begin
                  r_state <= S_STREAM;
               end else if (en) begin
                  r_state <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (en) begin
                  if (r_drain_cnt == DCW'(1)) begin
                     r_state <= S_DONE;
                  end
                  r_drain_cnt <= r_drain_cnt - DCW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Row i is a chain of i+1 registers so lane i lags stage 0 by exactly i en-edges.
   for (genvar gi = 0; gi < N; gi++) begin : g_row
      logic [DW-1:0] r_dat [0:gi];
      logic [gi:0]   r_vld;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k <= gi; k++) begin
               r_dat[k] <= '0;
            end
            r_vld <= '0;
         end else if (en) begin
            r_dat[0] <= w_pop ? w_head_data[gi*DW +: DW] : '0;
            r_vld[0] <= w_pop;
            for (int k = 1; k <= gi; k++) begin
               r_dat[k] <= r_dat[k-1];
               r_vld[k] <= r_vld[k-1];
            end
         end
      end

      assign row_a[gi*DW +: DW] = r_dat[gi];
      assign row_valid[gi]      = r_vld[gi];
   end

endmodule
